// File: rtl/ssp_rx_engine.sv
// SSP slave receive engine: synchronises the serial inputs to PCLK,
// deserialises WORD_SIZE-bit frames and strobes each word into the RX FIFO.
module ssp_rx_engine #(
    parameter int WORD_SIZE   = 8,
    parameter bit MSB_FIRST   = 1'b1,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 PCLK,
    input  logic                 CLEAR,
    input  logic                 ENABLE,
    input  logic                 SSPCLKIN,
    input  logic                 SSPFSSIN,
    input  logic                 SSPRXD,
    input  logic                 FIFOFULL,
    input  logic                 OVR_CLR,
    output logic [WORD_SIZE-1:0] RXDATA,
    output logic                 RXWRITE,
    output logic                 RXBUSY,
    output logic                 RXOVR,
    output logic                 RXFRMERR
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [4:0] LAST_BIT = 5'(WORD_SIZE - 1);

    logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
    logic [SYNC_STAGES-1:0] fss_sync_q, fss_sync_d;
    logic [SYNC_STAGES-1:0] rxd_sync_q, rxd_sync_d;
    logic                   sclk_dly_q, sclk_dly_d;

    state_t                 state_q, state_d;
    logic [4:0]             bitcnt_q, bitcnt_d;
    logic [WORD_SIZE-1:0]   sr_q, sr_d;
    logic [WORD_SIZE-1:0]   rxdata_q, rxdata_d;
    logic                   rxwrite_q, rxwrite_d;
    logic                   rxbusy_q, rxbusy_d;
    logic                   rxovr_q, rxovr_d;
    logic                   rxfrmerr_q, rxfrmerr_d;

    logic                   sclk_s, fss_s, rxd_s;
    logic                   rise, fall, ovr_set;
    logic [WORD_SIZE-1:0]   sr_shift;

    // Identical synchroniser chains keep clock, frame sync and data aligned
    always_comb begin
        sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], SSPCLKIN};
        fss_sync_d  = {fss_sync_q[SYNC_STAGES-2:0], SSPFSSIN};
        rxd_sync_d  = {rxd_sync_q[SYNC_STAGES-2:0], SSPRXD};
        sclk_s      = sclk_sync_q[SYNC_STAGES-1];
        fss_s       = fss_sync_q[SYNC_STAGES-1];
        rxd_s       = rxd_sync_q[SYNC_STAGES-1];
        sclk_dly_d  = sclk_s;
        rise        = sclk_s & ~sclk_dly_q;
        fall        = ~sclk_s & sclk_dly_q;
    end

    // Shift-register input depends on the configured bit order
    always_comb begin
        if (MSB_FIRST) begin
            sr_shift = {sr_q[WORD_SIZE-2:0], rxd_s};
        end else begin
            sr_shift = {rxd_s, sr_q[WORD_SIZE-1:1]};
        end
    end

    // Frame FSM next state; the word is completed on the rise carrying its last bit
    always_comb begin
        state_d    = state_q;
        bitcnt_d   = bitcnt_q;
        sr_d       = sr_q;
        rxdata_d   = rxdata_q;
        rxwrite_d  = 1'b0;
        rxfrmerr_d = rxfrmerr_q;
        ovr_set    = 1'b0;
        if (!ENABLE) begin
            state_d  = IDLE;
            bitcnt_d = 5'd0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (fall && fss_s) begin
                        state_d  = SHIFT;
                        bitcnt_d = 5'd0;
                    end
                end
                SHIFT: begin
                    if (rise) begin
                        sr_d     = sr_shift;
                        bitcnt_d = bitcnt_q + 5'd1;
                        if (bitcnt_q == LAST_BIT) begin
                            state_d = DONE;
                            if (FIFOFULL) begin
                                ovr_set = 1'b1;
                            end else begin
                                rxwrite_d = 1'b1;
                                rxdata_d  = sr_shift;
                            end
                        end
                    end else if (fall && fss_s && bitcnt_q != 5'd0) begin
                        rxfrmerr_d = 1'b1;
                        bitcnt_d   = 5'd0;
                    end
                end
                DONE: begin
                    if (fall) begin
                        state_d  = fss_s ? SHIFT : IDLE;
                        bitcnt_d = 5'd0;
                    end
                end
                default: begin
                    state_d  = IDLE;
                    bitcnt_d = 5'd0;
                end
            endcase
        end
        rxovr_d  = ovr_set | (rxovr_q & ~OVR_CLR);
        rxbusy_d = (state_d != IDLE);
    end

    // All state and registered outputs
    always_ff @(posedge PCLK or posedge CLEAR) begin
        if (CLEAR) begin
            sclk_sync_q <= '0;
            fss_sync_q  <= '0;
            rxd_sync_q  <= '0;
            sclk_dly_q  <= 1'b0;
            state_q     <= IDLE;
            bitcnt_q    <= 5'd0;
            sr_q        <= '0;
            rxdata_q    <= '0;
            rxwrite_q   <= 1'b0;
            rxbusy_q    <= 1'b0;
            rxovr_q     <= 1'b0;
            rxfrmerr_q  <= 1'b0;
        end else begin
            sclk_sync_q <= sclk_sync_d;
            fss_sync_q  <= fss_sync_d;
            rxd_sync_q  <= rxd_sync_d;
            sclk_dly_q  <= sclk_dly_d;
            state_q     <= state_d;
            bitcnt_q    <= bitcnt_d;
            sr_q        <= sr_d;
            rxdata_q    <= rxdata_d;
            rxwrite_q   <= rxwrite_d;
            rxbusy_q    <= rxbusy_d;
            rxovr_q     <= rxovr_d;
            rxfrmerr_q  <= rxfrmerr_d;
        end
    end

    assign RXDATA   = rxdata_q;
    assign RXWRITE  = rxwrite_q;
    assign RXBUSY   = rxbusy_q;
    assign RXOVR    = rxovr_q;
    assign RXFRMERR = rxfrmerr_q;

endmodule

// File: tb/tb_ssp_rx_engine.sv
// Directed bench for ssp_rx_engine: PCLK = 8x SSPCLKIN, WORD_SIZE=8,
// SYNC_STAGES=2, one MSB-first and one LSB-first instance on shared inputs.
module tb_ssp_rx_engine;

    logic       PCLK, CLEAR, ENABLE;
    logic       SSPCLKIN, SSPFSSIN, SSPRXD;
    logic       FIFOFULL, OVR_CLR;
    logic [7:0] RXDATA, rxdata_l;
    logic       RXWRITE, RXBUSY, RXOVR, RXFRMERR;
    logic       rxwrite_l, rxbusy_l, rxovr_l, rxfrmerr_l;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int rise_cyc = 0;
    int data_rise_cyc = 0;
    int wr_cnt = 0;
    int wr_cyc = 0;
    int wr_prev_cyc = 0;
    int busy_low = 0;
    int t2_base = 0;
    int base = 0;
    bit t2_mon = 0;
    bit prev_wr = 0;
    logic [7:0] wr_data = 0;
    logic [7:0] wr_prev_data = 0;

    ssp_rx_engine #(.WORD_SIZE(8), .MSB_FIRST(1'b1), .SYNC_STAGES(2)) dut (
        .PCLK(PCLK), .CLEAR(CLEAR), .ENABLE(ENABLE),
        .SSPCLKIN(SSPCLKIN), .SSPFSSIN(SSPFSSIN), .SSPRXD(SSPRXD),
        .FIFOFULL(FIFOFULL), .OVR_CLR(OVR_CLR),
        .RXDATA(RXDATA), .RXWRITE(RXWRITE), .RXBUSY(RXBUSY),
        .RXOVR(RXOVR), .RXFRMERR(RXFRMERR)
    );

    ssp_rx_engine #(.WORD_SIZE(8), .MSB_FIRST(1'b0), .SYNC_STAGES(2)) dut_lsb (
        .PCLK(PCLK), .CLEAR(CLEAR), .ENABLE(ENABLE),
        .SSPCLKIN(SSPCLKIN), .SSPFSSIN(SSPFSSIN), .SSPRXD(SSPRXD),
        .FIFOFULL(FIFOFULL), .OVR_CLR(OVR_CLR),
        .RXDATA(rxdata_l), .RXWRITE(rxwrite_l), .RXBUSY(rxbusy_l),
        .RXOVR(rxovr_l), .RXFRMERR(rxfrmerr_l)
    );

    initial begin
        PCLK = 1'b0;
        forever #5 PCLK = ~PCLK;
    end

    always @(posedge PCLK) cyc++;

    task automatic chk(input string tag, input int unsigned got,
                       input int unsigned exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    // Write monitor, sampled on the falling PCLK edge
    always @(negedge PCLK) begin
        if (RXWRITE) begin
            chk("wr_b2b", 32'(prev_wr), 0);
            wr_prev_data = wr_data;
            wr_data      = RXDATA;
            wr_prev_cyc  = wr_cyc;
            wr_cyc       = cyc;
            wr_cnt++;
        end
        if (t2_mon && wr_cnt == t2_base + 1 && !RXBUSY) busy_low++;
        prev_wr = RXWRITE;
    end

    // One SSPCLKIN period: fall, data/fss change mid-low, rise, high phase
    task automatic bp(input logic f, input logic d, input bit pc);
        SSPCLKIN = 1'b0;
        repeat (2) @(negedge PCLK);
        SSPFSSIN = f;
        SSPRXD   = d;
        repeat (2) @(negedge PCLK);
        SSPCLKIN = 1'b1;
        rise_cyc = cyc;
        repeat (2) @(negedge PCLK);
        if (pc) OVR_CLR = 1'b1;
        @(negedge PCLK);
        OVR_CLR = 1'b0;
        @(negedge PCLK);
    endtask

    task automatic bits(input logic [7:0] w, input logic last_f,
                        input bit pc);
        for (int i = 7; i >= 0; i--) begin
            bp((i == 0) ? last_f : 1'b0, w[i], (i == 0) ? pc : 1'b0);
        end
        data_rise_cyc = rise_cyc;
    endtask

    task automatic frame(input logic [7:0] w);
        bp(1'b1, 1'b0, 1'b0);
        bits(w, 1'b0, 1'b0);
        bp(1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        CLEAR    = 1'b1;
        ENABLE   = 1'b1;
        SSPCLKIN = 1'b1;
        SSPFSSIN = 1'b0;
        SSPRXD   = 1'b0;
        FIFOFULL = 1'b0;
        OVR_CLR  = 1'b0;
        repeat (3) @(negedge PCLK);
        chk("rst_data", RXDATA, 0);
        chk("rst_busy", RXBUSY, 0);
        chk("rst_write", RXWRITE, 0);
        chk("rst_ovr", RXOVR, 0);
        chk("rst_frm", RXFRMERR, 0);
        CLEAR = 1'b0;
        repeat (4) @(negedge PCLK);

        // single frame 0xA5
        base = wr_cnt;
        bp(1'b1, 1'b0, 1'b0);
        bits(8'hA5, 1'b0, 1'b0);
        chk("t1_busy_mid", RXBUSY, 1);
        bp(1'b0, 1'b0, 1'b0);
        chk("t1_writes", wr_cnt - base, 1);
        chk("t1_data", RXDATA, 8'hA5);
        chk("t1_busy", RXBUSY, 0);
        chk("t1_lat", wr_cyc - data_rise_cyc, 3);

        // back-to-back frames 0x3C, 0xC3
        base    = wr_cnt;
        t2_base = wr_cnt;
        t2_mon  = 1;
        bp(1'b1, 1'b0, 1'b0);
        bits(8'h3C, 1'b1, 1'b0);
        bits(8'hC3, 1'b0, 1'b0);
        bp(1'b0, 1'b0, 1'b0);
        t2_mon = 0;
        chk("t2_writes", wr_cnt - base, 2);
        chk("t2_first", wr_prev_data, 8'h3C);
        chk("t2_second", wr_data, 8'hC3);
        chk("t2_gap", wr_cyc - wr_prev_cyc, 64);
        chk("t2_busy_gap", busy_low, 0);
        chk("t2_busy_end", RXBUSY, 0);

        // bit order
        frame(8'h80);
        chk("t3_lsb_first", rxdata_l, 8'h01);
        chk("t3_msb_first", RXDATA, 8'h80);

        // overrun
        frame(8'hA5);
        chk("t4_prior", RXDATA, 8'hA5);
        base = wr_cnt;
        FIFOFULL = 1'b1;
        frame(8'h55);
        FIFOFULL = 1'b0;
        chk("t4_nowrite", wr_cnt - base, 0);
        chk("t4_ovr", RXOVR, 1);
        chk("t4_keep", RXDATA, 8'hA5);
        OVR_CLR = 1'b1;
        @(negedge PCLK);
        OVR_CLR = 1'b0;
        @(negedge PCLK);
        chk("t4_ovr_clr", RXOVR, 0);
        FIFOFULL = 1'b1;
        bp(1'b1, 1'b0, 1'b0);
        bits(8'h55, 1'b0, 1'b1);
        bp(1'b0, 1'b0, 1'b0);
        FIFOFULL = 1'b0;
        chk("t4_set_wins", RXOVR, 1);

        // resync after 3 bits, then 0x81
        base = wr_cnt;
        chk("t5_frm_pre", RXFRMERR, 0);
        bp(1'b1, 1'b0, 1'b0);
        bp(1'b0, 1'b1, 1'b0);
        bp(1'b0, 1'b1, 1'b0);
        bp(1'b1, 1'b1, 1'b0);
        bits(8'h81, 1'b0, 1'b0);
        bp(1'b0, 1'b0, 1'b0);
        chk("t5_frm", RXFRMERR, 1);
        chk("t5_writes", wr_cnt - base, 1);
        chk("t5_data", RXDATA, 8'h81);

        // CLEAR mid-word after 4 bits
        base = wr_cnt;
        bp(1'b1, 1'b0, 1'b0);
        repeat (4) bp(1'b0, 1'b1, 1'b0);
        #2 CLEAR = 1'b1;
        #1;
        chk("t6_clr_data", RXDATA, 0);
        chk("t6_clr_busy", RXBUSY, 0);
        chk("t6_clr_write", RXWRITE, 0);
        chk("t6_clr_ovr", RXOVR, 0);
        chk("t6_clr_frm", RXFRMERR, 0);
        repeat (2) @(negedge PCLK);
        CLEAR = 1'b0;
        repeat (4) bp(1'b0, 1'b1, 1'b0);
        chk("t6_clr_nowrite", wr_cnt - base, 0);
        frame(8'h7E);
        chk("t6_data", RXDATA, 8'h7E);

        // re-arm sticky flags, then ENABLE=0 mid-word
        FIFOFULL = 1'b1;
        frame(8'h11);
        FIFOFULL = 1'b0;
        bp(1'b1, 1'b0, 1'b0);
        bp(1'b0, 1'b1, 1'b0);
        bp(1'b1, 1'b0, 1'b0);
        bits(8'h22, 1'b0, 1'b0);
        bp(1'b0, 1'b0, 1'b0);
        chk("t6_rearm_data", RXDATA, 8'h22);
        base = wr_cnt;
        bp(1'b1, 1'b0, 1'b0);
        repeat (4) bp(1'b0, 1'b1, 1'b0);
        ENABLE = 1'b0;
        repeat (3) @(negedge PCLK);
        chk("t6_dis_busy", RXBUSY, 0);
        ENABLE = 1'b1;
        repeat (4) bp(1'b0, 1'b1, 1'b0);
        bp(1'b0, 1'b0, 1'b0);
        chk("t6_dis_nowrite", wr_cnt - base, 0);
        chk("t6_dis_ovr", RXOVR, 1);
        chk("t6_dis_frm", RXFRMERR, 1);
        chk("t6_dis_keep", RXDATA, 8'h22);
        frame(8'h5A);
        chk("t6_reen_data", RXDATA, 8'h5A);
        chk("t6_reen_writes", wr_cnt - base, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
